// File: rtl/bist_ctrl.sv
// BIST session sequencer: seeds the external pattern LFSR, compacts CUT responses into a MISR
// and compares the signature with a golden value. Optional BIST_SIG_OUT_EN exposes the MISR as 'signature'.
module bist_ctrl #(
    parameter int unsigned NBIT  = 4,
    parameter int unsigned NPAT  = 15,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NBIT-1:0] seed,
    input  logic [NBIT-1:0] golden,
    input  logic [NBIT-1:0] cut_resp,
    output logic            lfsr_rst,
    output logic [NBIT-1:0] lfsr_seed,
    output logic            busy,
    output logic            done,
    output logic            pass
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [NBIT-1:0] signature
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [NBIT-1:0]    r_seed_q;
    logic [NBIT-1:0]    r_golden_q;
    logic [NBIT-1:0]    r_misr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_pass;
    logic               w_start_ok;
    logic               w_last;
    logic [NBIT-1:0]    w_misr_shift;

    // start is only honoured when no session is in flight
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last       = (r_cnt == LAST_CNT);
    assign w_misr_shift = {r_misr[NBIT-2:0], r_misr[NBIT-1] ^ r_misr[NBIT-2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next_state = S_SEED;
            S_SEED:    w_next_state = S_RUN;
            S_RUN:     if (w_last) w_next_state = S_COMPARE;
            S_COMPARE: w_next_state = S_DONE;
            S_DONE:    if (start) w_next_state = S_SEED;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_SEED) || (r_state == S_RUN) || (r_state == S_COMPARE);
        lfsr_rst  = rst || (r_state == S_SEED);
        lfsr_seed = r_seed_q;
        done      = r_done;
        pass      = r_pass;
    end

`ifdef BIST_SIG_OUT_EN
    assign signature = r_misr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed_q   <= '0;
            r_golden_q <= '0;
            r_misr     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_seed_q   <= seed;
                        r_golden_q <= golden;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                S_SEED: begin
                    r_misr <= '0;
                    r_cnt  <= '0;
                end
                S_RUN: begin
                    r_misr <= w_misr_shift ^ cut_resp;
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_COMPARE: begin
                    r_pass <= (r_misr == r_golden_q);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: randomized sessions against a cycle-timed reference model,
// with an external 4-bit LFSR and a configurable CUT around the controller.
module tb_bist_ctrl;

    localparam int unsigned N = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] seed;
    logic [3:0] golden;
    logic [3:0] cut_resp;
    logic       lfsr_rst;
    logic [3:0] lfsr_seed;
    logic       busy;
    logic       done;
    logic       pass;

    logic       start1;
    logic [3:0] seed1;
    logic [3:0] golden1;
    logic [3:0] cut1;
    logic       lfsr_rst1;
    logic [3:0] lfsr_seed1;
    logic       busy1;
    logic       done1;
    logic       pass1;

`ifdef BIST_SIG_OUT_EN
    logic [3:0] signature;
    logic [3:0] signature1;
`endif

    logic [3:0] lfsr;
    logic       use_lfsr;
    logic [3:0] cut_xor;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    bist_ctrl #(.NBIT(4), .NPAT(N), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden),
        .cut_resp(cut_resp), .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed),
        .busy(busy), .done(done), .pass(pass)
`ifdef BIST_SIG_OUT_EN
        , .signature(signature)
`endif
    );

    bist_ctrl #(.NBIT(4), .NPAT(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .seed(seed1), .golden(golden1),
        .cut_resp(cut1), .lfsr_rst(lfsr_rst1), .lfsr_seed(lfsr_seed1),
        .busy(busy1), .done(done1), .pass(pass1)
`ifdef BIST_SIG_OUT_EN
        , .signature(signature1)
`endif
    );

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Pattern generator next to the controller; identity CUT when use_lfsr=1, stuck-at-0 otherwise
    always @(posedge clk) begin
        if (lfsr_rst) lfsr <= lfsr_seed;
        else          lfsr <= lfsr_next(lfsr);
    end

    assign cut_resp = (use_lfsr ? lfsr : 4'h0) ^ cut_xor;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one session starting at a negedge where the DUT is in IDLE or DONE.
    task automatic session(input logic [3:0] sd, input int gforce, input bit ident,
                           input bit noisy, input bit hold, input int mid_k,
                           input int idle_after);
        logic [3:0] pats [N];
        logic [3:0] xrs  [N];
        logic [3:0] p;
        logic [3:0] m;
        logic [3:0] gd;
        bit         exp_pass;
        p = sd;
        m = 4'h0;
        for (int k = 0; k < N; k++) begin
            pats[k] = p;
            xrs[k]  = noisy ? 4'($urandom) : 4'h0;
            m       = lfsr_next(m) ^ ((ident ? p : 4'h0) ^ xrs[k]);
            p       = lfsr_next(p);
        end
        if (gforce >= 0) gd = 4'(gforce);
        else             gd = ($urandom_range(1, 0) == 1) ? m : 4'($urandom);
        exp_pass = (gd == m);

        start = 1'b1; seed = sd; golden = gd; use_lfsr = ident; cut_xor = 4'($urandom);
        @(negedge clk);
        chk("seed_busy", 32'(busy), 32'd1);
        chk("seed_done", 32'(done), 32'd0);
        chk("seed_pass", 32'(pass), 32'd0);
        chk("seed_lfsr_rst", 32'(lfsr_rst), 32'd1);
        chk("seed_q", 32'(lfsr_seed), 32'(sd));
        start = hold; seed = 4'($urandom); golden = 4'($urandom); cut_xor = 4'($urandom);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_lfsr_rst", 32'(lfsr_rst), 32'd0);
            chk("run_seed_q", 32'(lfsr_seed), 32'(sd));
            chk("run_pattern", 32'(lfsr), 32'(pats[k]));
            cut_xor = xrs[k];
            start   = hold || (k == mid_k);
            seed    = 4'($urandom);
            golden  = 4'($urandom);
        end
        @(negedge clk);
        chk("cmp_busy", 32'(busy), 32'd1);
        chk("cmp_done", 32'(done), 32'd0);
        chk("cmp_pass", 32'(pass), 32'd0);
        cut_xor = 4'($urandom);
        start   = hold;
        @(negedge clk);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_done", 32'(done), 32'd1);
        chk("done_pass", 32'(pass), 32'(exp_pass));
        chk("done_lfsr_rst", 32'(lfsr_rst), 32'd0);
`ifdef BIST_SIG_OUT_EN
        chk("done_sig", 32'(signature), 32'(m));
`endif
        if (!hold) begin
            start = 1'b0;
            for (int i = 0; i < idle_after; i++) begin
                cut_xor = 4'($urandom);
                @(negedge clk);
                chk("hold_done", 32'(done), 32'd1);
                chk("hold_busy", 32'(busy), 32'd0);
                chk("hold_pass", 32'(pass), 32'(exp_pass));
                chk("hold_seed_q", 32'(lfsr_seed), 32'(sd));
`ifdef BIST_SIG_OUT_EN
                chk("hold_sig", 32'(signature), 32'(m));
`endif
            end
        end
    endtask

    // Single-pattern session on the NPAT=1 instance: signature equals the one absorbed response.
    task automatic short_session(input logic [3:0] sd, input logic [3:0] r, input logic [3:0] gd);
        start1 = 1'b1; seed1 = sd; golden1 = gd; cut1 = 4'($urandom);
        @(negedge clk);
        chk("n1_seed_busy", 32'(busy1), 32'd1);
        chk("n1_seed_lfsr_rst", 32'(lfsr_rst1), 32'd1);
        chk("n1_seed_done", 32'(done1), 32'd0);
        start1 = 1'b0; cut1 = 4'($urandom);
        @(negedge clk);
        chk("n1_run_busy", 32'(busy1), 32'd1);
        chk("n1_run_lfsr_rst", 32'(lfsr_rst1), 32'd0);
        chk("n1_run_seed_q", 32'(lfsr_seed1), 32'(sd));
        cut1 = r;
        @(negedge clk);
        chk("n1_cmp_busy", 32'(busy1), 32'd1);
        chk("n1_cmp_done", 32'(done1), 32'd0);
        cut1 = 4'($urandom);
        @(negedge clk);
        chk("n1_done_busy", 32'(busy1), 32'd0);
        chk("n1_done_done", 32'(done1), 32'd1);
        chk("n1_done_pass", 32'(pass1), 32'(r == gd));
`ifdef BIST_SIG_OUT_EN
        chk("n1_done_sig", 32'(signature1), 32'(r));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; seed = 4'h0; golden = 4'h0; use_lfsr = 1'b1; cut_xor = 4'h0;
        start1 = 1'b0; seed1 = 4'h0; golden1 = 4'h0; cut1 = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_lfsr_rst", 32'(lfsr_rst), 32'd1);
        chk("rst_seed_q", 32'(lfsr_seed), 32'd0);
        chk("rst_n1_done", 32'(done1), 32'd0);
`ifdef BIST_SIG_OUT_EN
        chk("rst_sig", 32'(signature), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("idle_lfsr_rst", 32'(lfsr_rst), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Identity CUT from seed F: signature 7
        session(4'hF, 7, 1'b1, 1'b0, 1'b0, -1, 2);
        session(4'hF, 0, 1'b1, 1'b0, 1'b0, -1, 1);
        session(4'hF, 7, 1'b0, 1'b0, 1'b0, -1, 1);
        // start mid-RUN is ignored, then immediate restart from DONE
        session(4'hF, 7, 1'b1, 1'b0, 1'b0, 5, 0);
        session(4'hF, 0, 1'b1, 1'b0, 1'b0, -1, 1);
        // start held high keeps retriggering from DONE
        session(4'hF, 7, 1'b1, 1'b0, 1'b1, -1, 0);
        session(4'h9, -1, 1'b1, 1'b1, 1'b1, -1, 0);
        session(4'h3, -1, 1'b1, 1'b0, 1'b0, -1, 1);

        for (int s = 0; s < 14; s++) begin
            session(4'($urandom), -1, 1'($urandom), 1'($urandom), (s < 13) ? 1'($urandom) : 1'b0,
                    ($urandom_range(1, 0) == 1) ? int'($urandom_range(N - 1, 0)) : -1,
                    int'($urandom_range(2, 0)));
        end

        // Reset asserted mid-RUN with cnt=5
        start = 1'b1; seed = 4'hF; golden = 4'h7; use_lfsr = 1'b1; cut_xor = 4'h0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_lfsr_rst", 32'(lfsr_rst), 32'd1);
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_lfsr_rst2", 32'(lfsr_rst), 32'd1);
        chk("mid_rst_seed_q", 32'(lfsr_seed), 32'd0);
`ifdef BIST_SIG_OUT_EN
        chk("mid_rst_sig", 32'(signature), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_lfsr_rst", 32'(lfsr_rst), 32'd0);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        session(4'($urandom), -1, 1'b1, 1'b1, 1'b0, -1, 1);

        for (int s = 0; s < 6; s++) begin
            logic [3:0] r;
            r = 4'($urandom);
            short_session(4'($urandom), r, ($urandom_range(1, 0) == 1) ? r : 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
